// File: rtl/alu_ctrl_seq_if.sv
// Handshake and control-word bundle between the main control FSM (master)
// and the ALU control sequencer (slave).
interface alu_ctrl_seq_if;
  logic       start;
  logic       kill;
  logic [1:0] alu_op;
  logic [4:0] func;
  logic       is_imm;
  logic       ready;
  logic [4:0] alu_cntrl;
  logic       alu_en;
  logic       busy;
  logic       done;
  logic       illegal;

  modport master (
    output start, kill, alu_op, func, is_imm,
    input  ready, alu_cntrl, alu_en, busy, done, illegal
  );

  modport slave (
    input  start, kill, alu_op, func, is_imm,
    output ready, alu_cntrl, alu_en, busy, done, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes alu_op/func into a held 5-bit control word and
// pulses done after the op latency. Define ALU_CTRL_MEXT_EN for M-extension ops.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  if (MUL_LAT < 1 || DIV_LAT < 1 || CNT_W < 1) begin : g_bad_param
    $error("alu_ctrl_seq: MUL_LAT, DIV_LAT and CNT_W must all be >= 1");
  end

  state_t     state_q, state_d;
  logic [4:0] cntrl_q, cntrl_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ill_q, ill_d;

  logic       mext_s;
  logic       f7b5_s;
  logic [2:0] f3_s;
  logic [4:0] dec_cntrl_s;
  logic       dec_en_s;
  logic       dec_ill_s;
  logic       ready_s;
  logic       accept_s;

`ifdef ALU_CTRL_MEXT_EN
  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_t;

  lat_t             dec_lat_s;
  logic [CNT_W-1:0] cnt_load_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign mext_s   = bus.func[4];
  assign f7b5_s   = bus.func[3];
  assign f3_s     = bus.func[2:0];
  assign ready_s  = (state_q == IDLE) || done_q;
  assign accept_s = bus.start && ready_s && !bus.kill;

  // Combinational decode of the presented instruction fields.
  always_comb begin
    dec_cntrl_s = 5'b00000;
    dec_en_s    = 1'b0;
    dec_ill_s   = 1'b0;
`ifdef ALU_CTRL_MEXT_EN
    dec_lat_s   = LAT_ONE;
`endif
    case (bus.alu_op)
      2'b00: begin
        dec_en_s = 1'b0;
      end
      2'b01: begin
        dec_en_s = 1'b1;
      end
      2'b10: begin
        if (mext_s) begin
`ifdef ALU_CTRL_MEXT_EN
          if (bus.is_imm) begin
            dec_ill_s = 1'b1;
          end else begin
            dec_cntrl_s = {2'b10, f3_s};
            dec_en_s    = 1'b1;
            dec_lat_s   = f3_s[2] ? LAT_DIV : LAT_MUL;
          end
`else
          dec_ill_s = 1'b1;
`endif
        end else if (f7b5_s && !bus.is_imm && (f3_s != 3'b000) && (f3_s != 3'b101)) begin
          dec_ill_s = 1'b1;
        end else begin
          dec_en_s = 1'b1;
          // ADDI ignores f7b5; shift-right uses f7b5 for both R and I forms.
          case (f3_s)
            3'b000:  dec_cntrl_s = (f7b5_s && !bus.is_imm) ? 5'b01001 : 5'b01000;
            3'b001:  dec_cntrl_s = 5'b00011;
            3'b010:  dec_cntrl_s = 5'b01100;
            3'b011:  dec_cntrl_s = 5'b00100;
            3'b100:  dec_cntrl_s = 5'b00110;
            3'b101:  dec_cntrl_s = f7b5_s ? 5'b01010 : 5'b00010;
            3'b110:  dec_cntrl_s = 5'b00111;
            3'b111:  dec_cntrl_s = 5'b01011;
            default: dec_cntrl_s = 5'b00000;
          endcase
        end
      end
      2'b11: begin
        dec_en_s = 1'b1;
        case (f3_s)
          3'b000:  dec_cntrl_s = 5'b01101;
          3'b001:  dec_cntrl_s = 5'b01111;
          3'b100:  dec_cntrl_s = 5'b01100;
          3'b101:  dec_cntrl_s = 5'b01101;
          3'b110:  dec_cntrl_s = 5'b00100;
          3'b111:  dec_cntrl_s = 5'b00101;
          default: begin
            dec_en_s  = 1'b0;
            dec_ill_s = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
  end

`ifdef ALU_CTRL_MEXT_EN
  // Counter preload is latency minus one so a count of zero marks the done cycle.
  always_comb begin
    case (dec_lat_s)
      LAT_MUL: cnt_load_s = CNT_W'(MUL_LAT - 1);
      LAT_DIV: cnt_load_s = CNT_W'(DIV_LAT - 1);
      default: cnt_load_s = {CNT_W{1'b0}};
    endcase
  end
`endif

  // Next-state logic; kill takes priority over a same-cycle accept.
  always_comb begin
    state_d = state_q;
    cntrl_d = cntrl_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MEXT_EN
    cnt_d   = cnt_q;
`endif
    if (bus.kill) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      ill_d   = 1'b0;
`ifdef ALU_CTRL_MEXT_EN
      cnt_d   = {CNT_W{1'b0}};
`endif
    end else if (accept_s) begin
      state_d = BUSY;
      cntrl_d = dec_cntrl_s;
      en_d    = dec_en_s;
      busy_d  = 1'b1;
      ill_d   = dec_ill_s;
`ifdef ALU_CTRL_MEXT_EN
      cnt_d   = cnt_load_s;
      done_d  = (cnt_load_s == {CNT_W{1'b0}});
`else
      done_d  = 1'b1;
`endif
    end else if (done_q) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      ill_d   = 1'b0;
    end else if (state_q == BUSY) begin
`ifdef ALU_CTRL_MEXT_EN
      if (cnt_q != {CNT_W{1'b0}}) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      done_d = (cnt_q == CNT_W'(1));
`else
      done_d = 1'b0;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cntrl_q <= 5'b00000;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MEXT_EN
      cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      cntrl_q <= cntrl_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MEXT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.ready     = ready_s;
  assign bus.alu_cntrl = cntrl_q;
  assign bus.alu_en    = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq; exercises M-extension timing when
// ALU_CTRL_MEXT_EN is defined, otherwise checks that M ops are flagged illegal.
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic [4:0] cntrl;
    logic       ill;
    logic       en;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  exp_t got;
  exp_t want;

  always #5 clk = ~clk;

  alu_ctrl_seq_if bus();

  alu_ctrl_seq #(.MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic drive(input logic [1:0] op, input logic [4:0] f, input logic imm, input logic st);
    bus.alu_op = op;
    bus.func   = f;
    bus.is_imm = imm;
    bus.start  = st;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.kill = 1'b0;
    drive(2'b00, 5'b00000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.alu_cntrl !== 5'b00000) $display("FAIL reset_cntrl got %b want 00000", bus.alu_cntrl); else pass_cnt++;
    total_cnt++; if (bus.alu_en !== 1'b0) $display("FAIL reset_en got %b want 0", bus.alu_en); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", bus.illegal); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Entry layout: {alu_op, func, is_imm, cntrl, illegal, alu_en}
  task automatic test_decode();
    logic [14:0] tbl [27];
    tbl = '{
      15'b10_01101_0_01010_0_1, 15'b10_01000_1_01000_0_1, 15'b10_01000_0_01001_0_1,
      15'b10_00000_0_01000_0_1, 15'b10_00001_0_00011_0_1, 15'b10_00010_1_01100_0_1,
      15'b10_00011_0_00100_0_1, 15'b10_00100_0_00110_0_1, 15'b10_00101_0_00010_0_1,
      15'b10_01101_1_01010_0_1, 15'b10_00110_0_00111_0_1, 15'b10_00111_0_01011_0_1,
      15'b10_01111_0_00000_1_0, 15'b10_01001_0_00000_1_0, 15'b10_01001_1_00011_0_1,
      15'b00_10111_0_00000_0_0, 15'b01_01010_1_00000_0_1, 15'b11_00000_0_01101_0_1,
      15'b11_00001_0_01111_0_1, 15'b11_00100_0_01100_0_1, 15'b11_00101_0_01101_0_1,
      15'b11_00110_0_00100_0_1, 15'b11_00111_0_00101_0_1, 15'b11_00010_0_00000_1_0,
      15'b11_00011_0_00000_1_0, 15'b10_10000_1_00000_1_0,
`ifdef ALU_CTRL_MEXT_EN
      15'b10_11000_1_00000_1_0
`else
      15'b10_10100_0_00000_1_0
`endif
    };
    for (int i = 0; i < 27; i++) begin
      logic [14:0] e;
      e = tbl[i];
      total_cnt++; if (bus.ready !== 1'b1) $display("FAIL dec_ready[%0d] got %b want 1", i, bus.ready); else pass_cnt++;
      drive(e[14:13], e[12:8], e[7], 1'b1);
      sb.push_back(exp_t'(e[6:0]));
      @(negedge clk);
      bus.start = 1'b0;
      total_cnt++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) $display("FAIL dec_done[%0d] got done=%b busy=%b want 1 1", i, bus.done, bus.busy); else pass_cnt++;
      want = sb.pop_front();
      got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
      total_cnt++; if (got !== want) $display("FAIL dec_word[%0d] got cntrl=%b ill=%b en=%b want cntrl=%b ill=%b en=%b", i, got.cntrl, got.ill, got.en, want.cntrl, want.ill, want.en); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.alu_en !== 1'b0) $display("FAIL dec_idle[%0d] got done=%b busy=%b en=%b want 0 0 0", i, bus.done, bus.busy, bus.alu_en); else pass_cnt++;
      total_cnt++; if (bus.alu_cntrl !== want.cntrl) $display("FAIL dec_hold[%0d] got %b want %b", i, bus.alu_cntrl, want.cntrl); else pass_cnt++;
    end
  endtask

`ifdef ALU_CTRL_MEXT_EN
  task automatic test_mext_latency();
    int n;
    drive(2'b10, 5'b10000, 1'b0, 1'b1);
    sb.push_back('{cntrl: 5'b10000, ill: 1'b0, en: 1'b1});
    @(negedge clk);
    drive(2'b10, 5'b00000, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      total_cnt++; if (bus.busy !== 1'b1 || bus.done !== (c == 3) || bus.alu_cntrl !== 5'b10000) $display("FAIL mul_cycle[%0d] got busy=%b done=%b cntrl=%b want 1 %b 10000", c, bus.busy, bus.done, bus.alu_cntrl, (c == 3)); else pass_cnt++;
      if (c == 1) begin
        total_cnt++; if (bus.ready !== 1'b0) $display("FAIL mul_ready got %b want 0", bus.ready); else pass_cnt++;
      end
      if (c == 2) bus.start = 1'b0;
      if (c == 3) begin
        want = sb.pop_front();
        got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
        total_cnt++; if (got !== want) $display("FAIL mul_word got %b want %b", got, want); else pass_cnt++;
      end
      if (c < 3) @(negedge clk);
    end
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mul_end got busy=%b done=%b want 0 0", bus.busy, bus.done); else pass_cnt++;

    drive(2'b10, 5'b10101, 1'b0, 1'b1);
    sb.push_back('{cntrl: 5'b10101, ill: 1'b0, en: 1'b1});
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (n !== 33) $display("FAIL div_latency got %0d want 33", n); else pass_cnt++;
    want = sb.pop_front();
    got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
    total_cnt++; if (got !== want) $display("FAIL div_word got %b want %b", got, want); else pass_cnt++;
    @(negedge clk);
  endtask
`else
  task automatic test_mext_latency();
    drive(2'b10, 5'b10000, 1'b0, 1'b1);
    sb.push_back('{cntrl: 5'b00000, ill: 1'b1, en: 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    total_cnt++; if (bus.done !== 1'b1) $display("FAIL nomext_done got %b want 1", bus.done); else pass_cnt++;
    want = sb.pop_front();
    got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
    total_cnt++; if (got !== want) $display("FAIL nomext_word got %b want %b", got, want); else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  task automatic test_kill();
    int seen;
`ifdef ALU_CTRL_MEXT_EN
    drive(2'b10, 5'b10101, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL kill_pre got busy=%b done=%b want 1 0", bus.busy, bus.done); else pass_cnt++;
    @(negedge clk);
`else
    drive(2'b10, 5'b00000, 1'b0, 1'b1);
    sb.push_back('{cntrl: 5'b01000, ill: 1'b0, en: 1'b1});
    @(negedge clk);
    total_cnt++; if (bus.done !== 1'b1) $display("FAIL kill_pre got done=%b want 1", bus.done); else pass_cnt++;
    want = sb.pop_front();
    got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
    total_cnt++; if (got !== want) $display("FAIL kill_pre_word got %b want %b", got, want); else pass_cnt++;
`endif
    bus.kill = 1'b1;
    drive(2'b10, 5'b01000, 1'b0, 1'b1);
    @(negedge clk);
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_en !== 1'b0 || bus.illegal !== 1'b0) $display("FAIL kill_post got busy=%b done=%b en=%b ill=%b want 0 0 0 0", bus.busy, bus.done, bus.alu_en, bus.illegal); else pass_cnt++;
    total_cnt++; if (bus.ready !== 1'b1) $display("FAIL kill_ready got %b want 1", bus.ready); else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL kill_quiet got %0d active cycles want 0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [14:0] ops [3];
    ops = '{15'b10_00000_0_01000_0_1, 15'b11_00001_0_01111_0_1, 15'b01_00010_0_00000_0_1};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i][14:13], ops[i][12:8], ops[i][7], 1'b1);
      sb.push_back(exp_t'(ops[i][6:0]));
      @(negedge clk);
      total_cnt++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) $display("FAIL b2b_done[%0d] got done=%b busy=%b want 1 1", i, bus.done, bus.busy); else pass_cnt++;
      want = sb.pop_front();
      got  = {bus.alu_cntrl, bus.illegal, bus.alu_en};
      total_cnt++; if (got !== want) $display("FAIL b2b_word[%0d] got %b want %b", i, got, want); else pass_cnt++;
    end
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL b2b_end got done=%b busy=%b want 0 0", bus.done, bus.busy); else pass_cnt++;
    total_cnt++; if (sb.size() !== 0) $display("FAIL sb_empty got %0d want 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(2'b10, 5'b10000, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    #1;
    total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_en !== 1'b0 || bus.ready !== 1'b1) $display("FAIL arst_now got busy=%b done=%b en=%b ready=%b want 0 0 0 1", bus.busy, bus.done, bus.alu_en, bus.ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL arst_after got done=%b busy=%b want 0 0", bus.done, bus.busy); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_mext_latency();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
